// File: rtl/sample_averager.sv
// Block-averaging decimator: sums 2^n valid signed samples, emits the mean as a held word plus a 1-cycle pulse.
// Latency: out_valid/out_data update on the edge after the cycle carrying the block's last valid sample.
// Backpressure: none; one sample per cycle is always accepted, in_valid gaps are skipped.
//
// Ports:
//   clk, aresetn          clock; synchronous active-low reset
//   in_data, in_valid     signed input sample and its qualifier
//   enable                1 = averaging; 0 = idle, partial block discarded
//   sync                  restart block alignment (sample on the same cycle becomes sample 0)
//   log2_n                averaging exponent, clamped to MAX_LOG2_N, latched at block start
//   out_data, out_valid   averaged word (held between pulses) and its update pulse
//   overrun               sticky: a partial block was aborted by sync or a log2_n change
//
// Build option: define AVG_ROUND_EN for round-half-up averaging instead of truncation.

module sample_averager #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOG2_N = 6
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    input  logic                         enable,
    input  logic                         sync,
    input  logic [2:0]                   log2_n,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         overrun
);

    // One guard bit above 2^MAX_LOG2_N full-scale samples absorbs the rounding term.
    localparam int ACC_W = DATA_WIDTH + MAX_LOG2_N + 1;
    // Counter is one bit wider than needed so the block-length mask never wraps.
    localparam int CNT_W = MAX_LOG2_N + 1;
    localparam logic [2:0] MAX_N = 3'(MAX_LOG2_N);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                         state_q, state_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [2:0]                     n_act_q, n_act_d;
    logic [2:0]                     log2_n_prev_q, log2_n_prev_d;
    logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           overrun_q, overrun_d;

    logic [2:0]                     n_clamp;
    logic [2:0]                     n_eff;
    logic signed [ACC_W-1:0]        acc_base;
    logic [CNT_W-1:0]               cnt_base;
    logic signed [ACC_W-1:0]        in_ext;
    logic signed [ACC_W-1:0]        sum;
    logic signed [ACC_W-1:0]        rnd;
    logic signed [ACC_W-1:0]        sum_rnd;
    logic signed [ACC_W-1:0]        shifted;
    logic                           blk_last;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        n_act_d       = n_act_q;
        log2_n_prev_d = log2_n;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        overrun_d     = overrun_q;

        n_clamp = (log2_n > MAX_N) ? MAX_N : log2_n;

        // IDLE and sync both start a fresh block this cycle.
        acc_base = (sync || state_q == IDLE) ? '0 : acc_q;
        cnt_base = (sync || state_q == IDLE) ? '0 : cnt_q;

        // At block start the exponent comes straight from the port so that
        // sample 0 already uses the new block length (matters for n = 0).
        n_eff = (cnt_base == '0) ? n_clamp : n_act_q;

        in_ext   = {{(ACC_W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
        sum      = acc_base + in_ext;
        blk_last = (cnt_base == ((CNT_W'(1) << n_eff) - CNT_W'(1)));

`ifdef AVG_ROUND_EN
        rnd = (n_eff != 3'd0) ? (ACC_W'(1) << (n_eff - 3'd1)) : '0;
`else
        rnd = '0;
`endif
        sum_rnd = sum + rnd;
        shifted = sum_rnd >>> n_eff;

        // A mid-block exponent change is ignored until the next block, but flagged.
        if (log2_n != log2_n_prev_q && cnt_q != '0) begin
            overrun_d = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            state_d = ACCUM;
            if (sync && cnt_q != '0) begin
                overrun_d = 1'b1;
            end
            if (cnt_base == '0) begin
                n_act_d = n_clamp;
            end
            acc_d = acc_base;
            cnt_d = cnt_base;
            if (in_valid) begin
                if (blk_last) begin
                    out_data_d  = shifted[DATA_WIDTH-1:0];
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_base + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            n_act_q       <= '0;
            log2_n_prev_q <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            n_act_q       <= n_act_d;
            log2_n_prev_q <= log2_n_prev_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_averager.sv
// Directed bench for sample_averager: expected averages are queued when a block's last sample is driven
// and compared (value and arrival cycle) when out_valid pulses.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.

module tb_sample_averager;

    logic               clk;
    logic               aresetn;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               enable;
    logic               sync;
    logic [2:0]         log2_n;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               overrun;

    typedef struct {
        logic signed [15:0] data;
        int                 cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   nchecks = 0;
    int   nerr    = 0;

    sample_averager #(
        .DATA_WIDTH (16),
        .MAX_LOG2_N (6)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .enable    (enable),
        .sync      (sync),
        .log2_n    (log2_n),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest queued expectation in value and cycle.
    always @(negedge clk) begin
        if (out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", 32'(out_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_data", out_data, e.data);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one cycle of inputs, then wait for the falling edge after the active edge.
    task automatic step(input logic v, input logic signed [15:0] d, input logic s);
        in_valid = v;
        in_data  = d;
        sync     = s;
        @(negedge clk);
    endtask

    // Call right before stepping the last sample of a block.
    task automatic expect_out(input logic signed [15:0] val);
        exp_t e;
        e.data = val;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step(1'b0, 16'sd0, 1'b0);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        enable   = 1'b0;
        sync     = 1'b0;
        log2_n   = 3'd2;
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        check("reset_out_data", out_data, 0);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_overrun", 32'(overrun), 0);

        // Mean of 1,2,3,4 (sum 10).
        enable = 1'b1;
        step(1'b1, 16'sd1, 1'b0);
        step(1'b1, 16'sd2, 1'b0);
        step(1'b1, 16'sd3, 1'b0);
`ifdef AVG_ROUND_EN
        expect_out(16'sd3);
`else
        expect_out(16'sd2);
`endif
        step(1'b1, 16'sd4, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
`ifdef AVG_ROUND_EN
        check("hold_after_t1", out_data, 3);
`else
        check("hold_after_t1", out_data, 2);
`endif

        // Negative sum -5: truncation floors, rounding goes toward +inf.
        step(1'b1, -16'sd1, 1'b0);
        step(1'b1, -16'sd1, 1'b0);
        step(1'b1, -16'sd1, 1'b0);
`ifdef AVG_ROUND_EN
        expect_out(-16'sd1);
`else
        expect_out(-16'sd2);
`endif
        step(1'b1, -16'sd2, 1'b0);
        step(1'b0, 16'sd0, 1'b0);

        // Full-scale blocks at the largest exponent; second block uses log2_n=7 which clamps to 6.
        log2_n = 3'd6;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) expect_out(16'sd32767);
            step(1'b1, 16'sd32767, 1'b0);
        end
        log2_n = 3'd7;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) expect_out(16'sh8000);
            step(1'b1, 16'sh8000, 1'b0);
        end
        step(1'b0, 16'sd0, 1'b0);

        // Pass-through: each valid sample pulses on the next cycle.
        log2_n = 3'd0;
        for (int d = 0; d < 10; d++) begin
            expect_out(16'(d));
            step(1'b1, 16'(d), 1'b0);
        end
        step(1'b0, 16'sd0, 1'b0);

        // Dropping enable mid-block discards the partial sum with no pulse and holds out_data.
        log2_n = 3'd2;
        step(1'b1, 16'sd500, 1'b0);
        step(1'b1, 16'sd500, 1'b0);
        enable = 1'b0;
        step(1'b1, 16'sd500, 1'b0);
        check("hold_after_disable", out_data, 9);
        enable = 1'b1;
        step(1'b1, 16'sd20, 1'b0);
        step(1'b1, 16'sd20, 1'b0);
        step(1'b1, 16'sd20, 1'b0);
        expect_out(16'sd20);
        step(1'b1, 16'sd20, 1'b0);
        step(1'b0, 16'sd0, 1'b0);
        check("overrun_clear_before_sync", 32'(overrun), 0);

        // Sync after 5 of 8 samples: aborted block never pulses, sync sample starts the new block.
        log2_n = 3'd3;
        for (int i = 0; i < 5; i++) step(1'b1, 16'sd100, 1'b0);
        check("overrun_pre_sync", 32'(overrun), 0);
        step(1'b1, 16'sd8, 1'b1);
        check("overrun_after_sync", 32'(overrun), 1);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) expect_out(16'sd8);
            step(1'b1, 16'sd8, 1'b0);
        end
        step(1'b0, 16'sd0, 1'b0);

        // Gapped input with a mid-block exponent change.
        do_reset();
        check("overrun_after_reset", 32'(overrun), 0);
        log2_n = 3'd2;
        step(1'b1, 16'sd4, 1'b0);  step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
        step(1'b1, 16'sd8, 1'b0);  step(1'b0, 16'sd0, 1'b0);
        log2_n = 3'd1;
        step(1'b0, 16'sd0, 1'b0);
        check("overrun_after_log2_change", 32'(overrun), 1);
        step(1'b1, 16'sd12, 1'b0); step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
        expect_out(16'sd10);
        step(1'b1, 16'sd16, 1'b0); step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
        step(1'b1, 16'sd5, 1'b0);  step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
        expect_out(16'sd6);
        step(1'b1, 16'sd7, 1'b0);  step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
        step(1'b1, 16'sd1, 1'b0);  step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);
`ifdef AVG_ROUND_EN
        expect_out(16'sd2);
`else
        expect_out(16'sd1);
`endif
        step(1'b1, 16'sd2, 1'b0);  step(1'b0, 16'sd0, 1'b0); step(1'b0, 16'sd0, 1'b0);

        // Reset mid-block: everything back to zero, and the partial block never pulses.
        step(1'b1, 16'sd100, 1'b0);
        do_reset();
        check("midreset_out_data", out_data, 0);
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_overrun", 32'(overrun), 0);
        step(1'b1, 16'sd100, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'sd0, 1'b0);

        check("all_pulses_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/sample_averager.md
# sample_averager

Block-averaging decimator on the ADC sample path, directly upstream of the bypass multiplexer. It accumulates 2^log2_n consecutive valid signed samples and emits their mean as one registered output word with a one-cycle valid pulse. The averaged word feeds the multiplexer's processed input while the raw ADC stream feeds its bypass input. Between pulses the output word holds its value, so a downstream register that samples continuously always sees the last completed average.

## Interface
- DATA_WIDTH, 16, sample width; two's-complement signed
- MAX_LOG2_N, 6, largest supported averaging exponent (block of up to 64 samples)

Ports:
- clk  in  1  sample clock
- aresetn  in  1  reset; synchronous, active-low
- in_data  in  DATA_WIDTH  signed input sample
- in_valid  in  1  in_data valid this cycle
- enable  in  1  1 = averaging active; 0 = idle, partial sum discarded
- sync  in  1  single-cycle restart of block alignment
- log2_n  in  3  averaging exponent; values above MAX_LOG2_N clamp to MAX_LOG2_N
- out_data  out  DATA_WIDTH  signed averaged sample, held between pulses
- out_valid  out  1  one-cycle pulse when out_data updates
- overrun  out  1  sticky; set when sync or a log2_n change discards a partial block

## Operation
- Reset values: out_data = 0, out_valid = 0, overrun = 0, accumulator = 0, sample counter = 0, state = IDLE.
- States:
  - IDLE: entered from reset or when enable = 0; accumulator and counter held at 0.
  - ACCUM: entered on the first cycle with enable = 1.
- Active exponent n_act: latched from the clamped log2_n at the start of each block (counter = 0). Changing log2_n mid-block has no effect until the next block. A change that happens while counter ≠ 0 sets overrun.
- Accumulator: signed, DATA_WIDTH+MAX_LOG2_N+1 bits. Each in_valid cycle adds the sign-extended in_data and increments the counter.
- Final sample of a block (counter = 2^n_act − 1 and in_valid = 1), all on the same edge:
  - sum = acc + in_data
  - out_data <= sum >>> n_act (arithmetic shift)
  - out_valid <= 1
  - acc <= 0, counter <= 0
- n_act = 0: pass-through; every valid sample produces a pulse.
- sync = 1:
  - counter and accumulator restart.
  - If in_valid is also high, that sample becomes sample 0 of the new block.
  - Sets overrun if counter ≠ 0.
- enable falling mid-block: partial sum discarded without a pulse; out_data holds.
- sync, enable = 0 and reset have no effect on a pulse already registered.
- overrun is cleared only by reset.
- in_valid = 0 cycles are skipped; the block counts only valid samples, so gaps are allowed.

## Timing
- Latency: out_valid is high exactly one cycle after the cycle carrying the last in_valid of the block. out_data changes on that same edge.
- out_valid is never high for two consecutive cycles unless n_act = 0 and in_valid is continuous.
- Throughput: one sample per cycle, no backpressure, no stalls.
- Reset asserted mid-block: on the next edge all state returns to reset values and no pulse is emitted.
- Overflow: impossible by construction; the accumulator width covers 2^MAX_LOG2_N full-scale samples plus the rounding term.

## Configuration
- AVG_ROUND_EN defined: when n_act > 0, out_data = (sum + 2^(n_act−1)) >>> n_act, i.e. round half toward +infinity. The result never exceeds the DATA_WIDTH range.
- AVG_ROUND_EN undefined: out_data = sum >>> n_act, i.e. truncation toward −infinity.
- n_act = 0 gives identical behaviour in both builds.

## Test plan
- Reset, then enable = 1, log2_n = 2, valid samples 1, 2, 3, 4 -> one pulse, one cycle after sample 4. out_data = 2 with AVG_ROUND_EN undefined, 3 with it defined.
- log2_n = 2, samples −1, −1, −1, −2 -> out_data = −2 truncating, −1 rounding.
- log2_n = 6, 64 samples of 32767, then 64 samples of −32768 -> pulses with out_data = 32767 then −32768; no wrap in either build.
- log2_n = 0, continuous in_valid with ramp 0..9 -> ten consecutive pulses, each out_data equal to the previous cycle's input.
- log2_n = 3, sync after 5 samples, sync cycle carrying value 8, then 7 more samples of 8 -> overrun = 1, next pulse out_data = 8, no pulse from the aborted block.
- log2_n = 2, in_valid gapped (valid every 3rd cycle) with log2_n changed to 1 after the 2nd sample -> first pulse averages 4 samples; next blocks average 2; overrun = 1. Then aresetn = 0 for one cycle mid-block -> all outputs 0, no pulse.
